// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Define DIV_SEQ_SIGNED_EN for two's-complement operands (truncating).
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             finish,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] p;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] p_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // P's top bit is kept in the wider shift so divisors above 2^(W-1) work
    always_comb begin
        p_sh    = {p, dvd[WIDTH-1]};
        diff    = p_sh - {1'b0, dvs};
        q_bit   = ~diff[WIDTH];
        p_nxt   = q_bit ? diff[WIDTH-1:0] : p_sh[WIDTH-1:0];
        dvd_nxt = {dvd[WIDTH-2:0], q_bit};
    end

`ifdef DIV_SEQ_SIGNED_EN
    logic neg_q;
    logic neg_r;

    always_comb begin
        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;
        q_fix = neg_q ? -dvd_nxt : dvd_nxt;
        r_fix = neg_r ? -p_nxt : p_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r <= a[WIDTH-1];
        end
    end
`else
    assign a_mag = a;
    assign b_mag = b;
    assign q_fix = dvd_nxt;
    assign r_fix = p_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            quo         <= '0;
            rem         <= '0;
            finish      <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
            dvd         <= '0;
            dvs         <= '0;
            p           <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (b == '0) begin
                            state       <= DONE;
                            finish      <= 1'b1;
                            quo         <= '1;
                            rem         <= a;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            dvd   <= a_mag;
                            dvs   <= b_mag;
                            p     <= '0;
                            cnt   <= CW'(WIDTH - 1);
                        end
                    end
                end
                CALC: begin
                    dvd <= dvd_nxt;
                    p   <= p_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state       <= DONE;
                        finish      <= 1'b1;
                        quo         <= q_fix;
                        rem         <= r_fix;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    finish <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    finish <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
